// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage of the RPN calculator CPU. It holds the PC,
// addresses the combinational instruction ROM, and registers the returned word.
// It presents the word to execute over a valid/ready handshake; jump/ATC
// redirects from execute reload the PC and discard the in-flight word.
// Ports:
//   clk, reset (sync, active-low), run (fetch enable)
//   rom_addr -> ROM, rom_data <- ROM (same cycle)
//   ir / ir_pc / ir_valid -> execute, ir_ready <- execute
//   jump_req / jump_addr <- execute redirect
// Optional feature: define BRANCH_BYPASS_EN for zero-bubble redirects.
// This drives the jump target to the ROM directly.
module instruction_fetch #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               jump_req,
    input  logic [ADDR_W-1:0]  jump_addr
);

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
    logic               ir_valid_q, ir_valid_d;

`ifdef BRANCH_BYPASS_EN
    // Only RUN honours jump_req, so the target is routed to the ROM only there.
    // Elsewhere the ROM must keep seeing the PC.
    assign rom_addr = (state_q == RUN && jump_req) ? jump_addr : pc_q;
`else
    assign rom_addr = pc_q;
`endif

    assign ir       = ir_q;
    assign ir_pc    = ir_pc_q;
    assign ir_valid = ir_valid_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= FILL;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    logic load;
    logic redirect;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        load       = 1'b0;
        redirect   = 1'b0;

        unique case (state_q)
            FILL, REDIRECT: begin
                load = run;
            end
            RUN: begin
                if (jump_req) begin
`ifdef BRANCH_BYPASS_EN
                    // rom_addr already carries jump_addr here.
                    if (run) load = 1'b1;
                    else     redirect = 1'b1;
`else
                    redirect = 1'b1;
`endif
                end else if (ir_valid_q && ir_ready && run) begin
                    load = 1'b1;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        if (load) begin
            ir_d       = rom_data;
            ir_pc_d    = rom_addr;
            ir_valid_d = 1'b1;
            pc_d       = rom_addr + ADDR_W'(1);
            state_d    = RUN;
        end else if (redirect) begin
            // The current ir counts as consumed; the target is fetched later.
            ir_valid_d = 1'b0;
            pc_d       = jump_addr;
            state_d    = REDIRECT;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed bench for instruction_fetch (default build).
// A second instance checks PC wrap from RESET_PC=254.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        ir_ready;
    logic        jump_req;
    logic [7:0]  jump_addr;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic [31:0] ir;
    logic [7:0]  ir_pc;
    logic        ir_valid;

    logic [7:0]  rom_addr2;
    logic [31:0] rom_data2;
    logic [31:0] ir2;
    logic [7:0]  ir_pc2;
    logic        ir_valid2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // ROM image: address 5 is a NOP, address 6 is the jmp(0) word.
    function automatic logic [31:0] rom_f(input logic [7:0] a);
        case (a)
            8'd5:    rom_f = 32'h0000_0000;
            8'd6:    rom_f = 32'h0600_0000;
            default: rom_f = {8'hA5, a, ~a, 8'h5A};
        endcase
    endfunction

    assign rom_data  = rom_f(rom_addr);
    assign rom_data2 = rom_f(rom_addr2);

    instruction_fetch dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .ir        (ir),
        .ir_pc     (ir_pc),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .jump_req  (jump_req),
        .jump_addr (jump_addr)
    );

    instruction_fetch #(.RESET_PC(8'd254)) dut_wrap (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .rom_addr  (rom_addr2),
        .rom_data  (rom_data2),
        .ir        (ir2),
        .ir_pc     (ir_pc2),
        .ir_valid  (ir_valid2),
        .ir_ready  (1'b1),
        .jump_req  (1'b0),
        .jump_addr (8'd0)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %h exp %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ir(input string tag, input logic [7:0] pc);
        check({tag, "_v"},  {31'd0, ir_valid}, 32'd1);
        check({tag, "_pc"}, {24'd0, ir_pc}, {24'd0, pc});
        check({tag, "_ir"}, ir, rom_f(pc));
    endtask

    task automatic chk_wrap(input string tag, input logic [7:0] pc);
        check({tag, "_v"},  {31'd0, ir_valid2}, 32'd1);
        check({tag, "_pc"}, {24'd0, ir_pc2}, {24'd0, pc});
        check({tag, "_ir"}, ir2, rom_f(pc));
    endtask

    initial begin
        reset = 1'b0; run = 1'b0; ir_ready = 1'b0;
        jump_req = 1'b0; jump_addr = 8'd0;
        tick(); tick();
        check("rst_v",    {31'd0, ir_valid}, 32'd0);
        check("rst_pc",   {24'd0, ir_pc}, 32'd0);
        check("rst_ir",   ir, 32'd0);
        check("rst_addr", {24'd0, rom_addr}, 32'd0);
        check("rst_addr2", {24'd0, rom_addr2}, 32'd254);
        check("rst_v2",   {31'd0, ir_valid2}, 32'd0);

        // Free run: one instruction per cycle, second DUT wraps.
        reset = 1'b1; run = 1'b1; ir_ready = 1'b1;
        tick(); chk_ir("seq0", 8'd0); chk_wrap("wrap254", 8'd254);
        tick(); chk_ir("seq1", 8'd1); chk_wrap("wrap255", 8'd255);
        tick(); chk_ir("seq2", 8'd2); chk_wrap("wrap0", 8'd0);
        tick(); chk_ir("seq3", 8'd3); chk_wrap("wrap1", 8'd1);

        // Stall 3 cycles at ir_pc=3.
        ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_ir("stall", 8'd3);
        end
        ir_ready = 1'b1;
        tick(); chk_ir("post_stall", 8'd4);
        tick(); chk_ir("nop5", 8'd5);
        tick(); chk_ir("jmp6", 8'd6);

        // Execute takes jmp(0) together with ir_ready.
        jump_req = 1'b1; jump_addr = 8'd0;
        tick();
        check("jmp0_bubble", {31'd0, ir_valid}, 32'd0);
        jump_req = 1'b0;
        tick(); chk_ir("jmp0_t", 8'd0);
        tick(); chk_ir("jmp0_n1", 8'd1);
        tick(); chk_ir("jmp0_n2", 8'd2);

        // Jump to 38 while ir_pc=2.
        jump_req = 1'b1; jump_addr = 8'd38;
        tick();
        check("j38_bubble", {31'd0, ir_valid}, 32'd0);
        check("j38_addr",   {24'd0, rom_addr}, 32'd38);
        jump_req = 1'b0;
        tick(); chk_ir("j38_t", 8'd38);
        tick(); chk_ir("j38_n", 8'd39);

        // Reset during the REDIRECT cycle.
        jump_req = 1'b1; jump_addr = 8'd100;
        tick();
        check("rr_bubble", {31'd0, ir_valid}, 32'd0);
        jump_req = 1'b0; reset = 1'b0;
        tick();
        check("rr_rst_v",  {31'd0, ir_valid}, 32'd0);
        check("rr_rst_pc", {24'd0, rom_addr}, 32'd0);
        reset = 1'b1;
        tick(); chk_ir("rr_first", 8'd0);

        // Jump while run=0: PC moves, fetch waits for run.
        run = 1'b0; ir_ready = 1'b0;
        jump_req = 1'b1; jump_addr = 8'd89;
        tick();
        check("r0_v", {31'd0, ir_valid}, 32'd0);
        jump_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("r0_hold_v",    {31'd0, ir_valid}, 32'd0);
            check("r0_hold_addr", {24'd0, rom_addr}, 32'd89);
        end
        run = 1'b1; ir_ready = 1'b1;
        tick(); chk_ir("r0_t", 8'd89);
        tick(); chk_ir("r0_n", 8'd90);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
